des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Iterative DES key schedule. It loads a 64-bit key and emits the 16 48-bit round subkeys K1..K16 (encrypt) or K16..K1 (decrypt), one per valid/ready handshake. Each subkey goes to the round stage, where it is XORed with the expanded right half to form the 6-bit addresses of S-box ROMs S1..S8. The block replaces per-round key storage with a single rotating C/D register pair.

## Interface
Parameters: none; all permutation and shift tables are fixed constants in the shared package.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- key_in  in  64  DES key; FIPS bit 1 = key_in[63]; parity bits 8,16,…,64 are ignored
- load  in  1  start request; sampled only in IDLE
- decrypt  in  1  order select, sampled with load; 0 = K1→K16, 1 = K16→K1
- subkey_ready  in  1  consumer accepts the current subkey
- subkey  out  48  current round subkey; FIPS bit 1 = subkey[47]; registered
- subkey_valid  out  1  subkey is valid
- round_idx  out  4  round number of the presented subkey minus 1 (0 = K1, 15 = K16)
- busy  out  1  high in EMIT
- done  out  1  one-cycle pulse after the 16th handshake

## Operation
- Shift schedule SHIFTS[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28).
- FSM has two states: IDLE and EMIT.
- **IDLE, load = 1:**
  - Compute C0/D0 = PC-1(key_in), 28 bits each.
  - Encrypt: C/D ← rotl(C0/D0, SHIFTS[1]); subkey ← PC-2 of that value; round_idx ← 0.
  - Decrypt: C/D ← C0/D0, because C16 = C0 after 28 total shifts; subkey ← PC-2(C0,D0); round_idx ← 15.
  - Latch the direction and go to EMIT.
- **EMIT:**
  - subkey_valid = 1 and busy = 1.
  - On handshake (subkey_valid & subkey_ready), if it is not the last round:
    - Encrypt: C/D ← rotl by SHIFTS[r+2]; round_idx increments.
    - Decrypt: C/D ← rotr by SHIFTS[r+1], where r = current round_idx; round_idx decrements.
    - subkey ← PC-2 of the new C/D.
  - On handshake for the last round (round_idx 15 when encrypting, 0 when decrypting): go to IDLE, subkey_valid ← 0, done ← 1 for one cycle.
- **Boundary conditions:**
  - load is ignored while in EMIT.
  - A load arriving in the same cycle that done is asserted is accepted, since the FSM is already in IDLE.
  - With no handshake, subkey and round_idx hold stable and subkey_valid stays high (backpressure).
  - subkey_ready while in IDLE has no effect.
  - rst asserted mid-sequence aborts immediately with no done pulse.
  - A key whose C0 and D0 are both all-zero or all-one (DES weak keys) produces 16 identical subkeys. This is legal behaviour and is not flagged.
- **Reset values:** subkey = 0, subkey_valid = 0, round_idx = 0, busy = 0, done = 0, C/D = 0, state = IDLE.

## Timing
- Load accepted at edge t → first subkey valid after edge t (cycle t+1). Latency is 1 cycle.
- With subkey_ready held high, one subkey per cycle: 16 subkeys over cycles t+1..t+16; done is high in cycle t+17.
- subkey is a register output with no combinational path from any input.
- subkey_valid does not depend combinationally on subkey_ready.
- Minimum period from one load to the next: 17 cycles.

## Structure
- Package des_pkg holds:
  - PC1_TABLE (56 entries) and PC2_TABLE (48 entries), 1-based FIPS indices
  - SHIFTS[1:16]
  - the FSM state enum (IDLE, EMIT)
  - typedefs for 28-bit half-keys and 48-bit subkeys
- Sub-module des_pc2: a purely combinational PC-2 mapping {C,D} (56 bits) → 48 bits. It is reused by any future unrolled key path.
- PC-1 and the rotates are inline in des_key_schedule.

## Test plan
- **Encrypt order:** key 0x133457799BBCDFF1, decrypt = 0, ready held high → K1 = 0x1B02EFFC7072 at t+1, K2 = 0x79AED9DBC9E5 at t+2, K16 = 0xCB3D8B0E17F5 at t+16; done at t+17; round_idx steps 0..15.
- **Decrypt order:** same key, decrypt = 1 → first subkey 0xCB3D8B0E17F5 with round_idx = 15; last subkey 0x1B02EFFC7072 with round_idx = 0; all 16 subkeys match the encrypt run in reverse.
- **Backpressure:** random ready pattern with 30% stalls → subkey and round_idx stable during every stall; exactly 16 handshakes; values identical to the first scenario.
- **Busy load:** load asserted with key 0xFFFF…FF at the 5th handshake → ignored; the sequence continues with the original key's subkeys.
- **Mid-sequence reset:** rst asserted after 8 handshakes → all outputs 0 asynchronously and no done pulse; a new load then produces K1 = 0x1B02EFFC7072 again.
- **Weak key:** key 0x0101010101010101 → all 16 subkeys = 0; back-to-back load in the done cycle is accepted.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key schedule tables, shift schedule, FSM state and half-key types
package des_pkg;

    typedef logic [27:0] half_t;
    typedef logic [47:0] subkey_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // 1-based FIPS bit indices; FIPS bit 1 is the MSB of the source vector.
    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFTS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic half_t rotl(input half_t h, input logic two);
        return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

    function automatic half_t rotr(input half_t h, input logic two);
        return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational PC-2 compression of {C,D} into a 48-bit subkey
// Ports:
//   cd     in  56  {C,D}; FIPS bit 1 = cd[55]
//   subkey out 48  PC-2 result; FIPS bit 1 = subkey[47]
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output subkey_t     subkey
);

    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign subkey[47-i] = cd[56-PC2_TABLE[i]];
    end

    // PC-2 drops FIPS bits 9, 18, 22, 25, 35, 38, 43 and 54.
    logic unused_dropped;
    assign unused_dropped = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - iterative DES key schedule emitting K1..K16 or K16..K1 over a handshake
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   key_in[63:0]        DES key (FIPS bit 1 = key_in[63]; parity bits ignored)
//   load, decrypt       start request and direction, sampled in IDLE
//   subkey_ready        consumer accepts the presented subkey
//   subkey[47:0]        registered round subkey
//   subkey_valid        subkey is valid
//   round_idx[3:0]      round number of the presented subkey minus 1
//   busy                high while emitting
//   done                one-cycle pulse after the 16th handshake
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        load,
    input  logic        decrypt,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    state_t      state_q, state_d;
    half_t       c_q, d_q, c_d, d_d;
    logic [3:0]  round_d;
    logic        dir_q, dir_d;
    logic        done_d;
    logic        upd;
    logic [55:0] cd0;
    subkey_t     pc2_out;
    logic [15:0] two_mask;

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign cd0[55-i] = key_in[64-PC1_TABLE[i]];
    end

    // two_mask[r] is set when round r+1 uses a double rotate.
    for (genvar i = 0; i < 16; i++) begin : g_shift
        assign two_mask[i] = (SHIFTS[i+1] == 2);
    end

    logic unused_parity;
    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    // The subkey register is fed from the next-state C/D, so the presented
    // subkey always matches the C/D held alongside it.
    des_pc2 u_pc2 (
        .cd     ({c_d, d_d}),
        .subkey (pc2_out)
    );

    assign subkey_valid = (state_q == EMIT);
    assign busy         = (state_q == EMIT);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_idx;
        dir_d   = dir_q;
        done_d  = 1'b0;
        upd     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    dir_d   = decrypt;
                    upd     = 1'b1;
                    state_d = EMIT;
                    if (decrypt) begin
                        // 28 total shifts bring C16/D16 back to C0/D0.
                        c_d     = cd0[55:28];
                        d_d     = cd0[27:0];
                        round_d = 4'd15;
                    end else begin
                        c_d     = rotl(cd0[55:28], two_mask[0]);
                        d_d     = rotl(cd0[27:0], two_mask[0]);
                        round_d = 4'd0;
                    end
                end
            end
            EMIT: begin
                if (subkey_ready) begin
                    if (dir_q ? (round_idx == 4'd0) : (round_idx == 4'd15)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (dir_q) begin
                        // Undo the shift that produced the current round.
                        c_d     = rotr(c_q, two_mask[round_idx]);
                        d_d     = rotr(d_q, two_mask[round_idx]);
                        round_d = round_idx - 4'd1;
                        upd     = 1'b1;
                    end else begin
                        c_d     = rotl(c_q, two_mask[round_idx + 4'd1]);
                        d_d     = rotl(d_q, two_mask[round_idx + 4'd1]);
                        round_d = round_idx + 4'd1;
                        upd     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            c_q       <= '0;
            d_q       <= '0;
            dir_q     <= 1'b0;
            round_idx <= '0;
            subkey    <= '0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            dir_q     <= dir_d;
            round_idx <= round_d;
            done      <= done_d;
            if (upd) begin
                subkey <= pc2_out;
            end
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - scoreboard testbench for des_key_schedule
module tb_des_key_schedule;
    import des_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key_in;
    logic        load;
    logic        decrypt;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  idx;
        logic [47:0] key;
    } exp_t;

    exp_t        q[$];
    logic [47:0] ref_ks [16];
    logic [47:0] got    [16];

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_WK = 64'h0101010101010101;
    localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
    localparam logic [47:0] K2_A   = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .load         (load),
        .decrypt      (decrypt),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    // Reference: each round rotates C0/D0 by the cumulative shift count directly.
    function automatic void model(input logic [63:0] k);
        logic [55:0] cd;
        logic [27:0] c0, d0, c, d;
        logic [55:0] x;
        int tot;
        tot = 0;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_TABLE[i]];
        c0 = cd[55:28];
        d0 = cd[27:0];
        for (int n = 1; n <= 16; n++) begin
            tot += SHIFTS[n];
            c = c0;
            d = d0;
            for (int j = 0; j < tot; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            x = {c, d};
            for (int i = 0; i < 48; i++) ref_ks[n-1][47-i] = x[56-PC2_TABLE[i]];
        end
    endfunction

    task automatic assert_load(input logic [63:0] k, input logic dec);
        exp_t e;
        int   r;
        key_in  = k;
        decrypt = dec;
        load    = 1'b1;
        model(k);
        q.delete();
        for (int i = 0; i < 16; i++) begin
            r     = dec ? 15 - i : i;
            e.idx = 4'(r);
            e.key = ref_ks[r];
            q.push_back(e);
        end
    endtask

    task automatic start(input logic [63:0] k, input logic dec);
        @(posedge clk);
        #1;
        assert_load(k, dec);
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Consumes up to max_hs subkeys; returns just after the last handshake edge.
    task automatic drain(input int stall_pct, input int busy_at, input int max_hs, output int hs);
        int          budget;
        bit          stalled;
        bit          rdy;
        logic [47:0] held_k;
        logic [3:0]  held_r;
        hs      = 0;
        budget  = 0;
        stalled = 0;
        held_k  = '0;
        held_r  = '0;
        while (hs < max_hs) begin
            @(negedge clk);
            budget++;
            if (budget > 400) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: %0d handshakes, required %0d", hs, max_hs);
                break;
            end
            if (stalled) begin
                checks++;
                if (subkey !== held_k || round_idx !== held_r) begin
                    errors++;
                    $display("FAIL stall_hold: got %h/%0d, required %h/%0d", subkey, round_idx, held_k, held_r);
                end
            end
            checks++;
            if (subkey_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL valid_busy: got %b/%b, required 1/1 at handshake %0d", subkey_valid, busy, hs);
            end
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got subkey %h, required none", subkey);
                break;
            end
            checks++;
            if ({round_idx, subkey} !== {q[0].idx, q[0].key}) begin
                errors++;
                $display("FAIL subkey: got %h idx %0d, required %h idx %0d", subkey, round_idx, q[0].key, q[0].idx);
            end
            rdy = ($urandom_range(99) >= 32'(stall_pct));
            if (hs == busy_at) begin
                rdy    = 1'b1;
                key_in = '1;
                load   = 1'b1;
            end
            subkey_ready = rdy;
            held_k = subkey;
            held_r = round_idx;
            if (rdy) got[hs] = subkey;
            @(posedge clk);
            #1;
            load         = 1'b0;
            subkey_ready = 1'b0;
            if (rdy) begin
                void'(q.pop_front());
                hs++;
                stalled = 0;
            end else begin
                stalled = 1;
            end
        end
    endtask

    task automatic check_done();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || subkey_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done/valid/busy %b%b%b, required 100", done, subkey_valid, busy);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got %b, required 0", done);
        end
    endtask

    task automatic check_hs(input int hs, input int want);
        checks++;
        if (hs !== want) begin
            errors++;
            $display("FAIL handshake_count: got %0d, required %0d", hs, want);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (subkey !== '0 || subkey_valid !== 1'b0 || round_idx !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h %b %0d %b %b, required all zero", subkey, subkey_valid, round_idx, busy, done);
        end
        @(negedge clk);
        rst          = 1'b0;
        subkey_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || subkey !== '0) begin
            errors++;
            $display("FAIL idle_ready: got valid %b busy %b done %b, required 0 0 0", subkey_valid, busy, done);
        end
        subkey_ready = 1'b0;
    endtask

    task automatic test_encrypt();
        int hs;
        start(KEY_A, 1'b0);
        drain(0, -1, 16, hs);
        check_hs(hs, 16);
        checks++;
        if (got[0] !== K1_A || got[1] !== K2_A || got[15] !== K16_A) begin
            errors++;
            $display("FAIL encrypt_vectors: got %h %h %h, required %h %h %h", got[0], got[1], got[15], K1_A, K2_A, K16_A);
        end
        check_done();
    endtask

    task automatic test_decrypt();
        int hs;
        start(KEY_A, 1'b1);
        drain(0, -1, 16, hs);
        check_hs(hs, 16);
        checks++;
        if (got[0] !== K16_A || got[15] !== K1_A) begin
            errors++;
            $display("FAIL decrypt_vectors: got %h %h, required %h %h", got[0], got[15], K16_A, K1_A);
        end
        check_done();
    endtask

    task automatic test_backpressure();
        int hs;
        start(KEY_A, 1'b0);
        drain(30, -1, 16, hs);
        check_hs(hs, 16);
        check_done();
    endtask

    task automatic test_busy_load();
        int hs;
        start(KEY_A, 1'b0);
        drain(0, 4, 16, hs);
        check_hs(hs, 16);
        check_done();
    endtask

    task automatic test_mid_reset();
        int hs;
        start(KEY_A, 1'b0);
        drain(0, -1, 8, hs);
        check_hs(hs, 8);
        rst = 1'b1;
        #1;
        checks++;
        if (subkey !== '0 || subkey_valid !== 1'b0 || round_idx !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h %b %0d %b %b, required all zero", subkey, subkey_valid, round_idx, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || subkey_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done: got done %b valid %b, required 0 0", done, subkey_valid);
            end
        end
        start(KEY_A, 1'b0);
        drain(0, -1, 16, hs);
        checks++;
        if (got[0] !== K1_A) begin
            errors++;
            $display("FAIL reload_k1: got %h, required %h", got[0], K1_A);
        end
        check_done();
    endtask

    task automatic test_weak_key();
        int          hs;
        logic [47:0] acc;
        start(KEY_WK, 1'b0);
        drain(0, -1, 16, hs);
        acc = '0;
        for (int i = 0; i < 16; i++) acc |= got[i];
        checks++;
        if (acc !== '0) begin
            errors++;
            $display("FAIL weak_key: got OR of subkeys %h, required 0", acc);
        end
        // Load in the done cycle: the FSM is already idle.
        assert_load(KEY_WK, 1'b0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got %b, required 1", done);
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        drain(0, -1, 16, hs);
        check_hs(hs, 16);
        check_done();
    endtask

    initial begin
        rst          = 1'b1;
        key_in       = '0;
        load         = 1'b0;
        decrypt      = 1'b0;
        subkey_ready = 1'b0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_busy_load();
        test_mid_reset();
        test_weak_key();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
